fp_add_pipe: RTL and testbench
==============================

Name: fp_add_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754 adder/subtractor with a valid/ready handshake and full backpressure. It supports all five RISC-V rounding modes and produces sticky-accurate rounding plus exception flags. It is the successor of the single-cycle binary32 adder and sits in the ALU datapath between operand issue and writeback.

Parameters:
EXP_W, 8, exponent field width (binary32 = 8, binary64 = 11)
MAN_W, 23, stored fraction width (binary32 = 23, binary64 = 52)
FP_W, 1+EXP_W+MAN_W, derived total width; not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  pipe can accept the beat
fp_a  in  FP_W  operand A
fp_b  in  FP_W  operand B
op_sub  in  1  1 = compute A - B (flip sign of B)
r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others are treated as RNE
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
fp_result  out  FP_W  rounded result
flag_invalid  out  1  NV flag
flag_overflow  out  1  OF flag
flag_underflow  out  1  UF flag
flag_inexact  out  1  NX flag

Behaviour:
- Reset (async assert, sync deassert is external): all stage valid bits = 0; out_valid = 0; fp_result = 0; all flags = 0; in_ready = 1 once reset releases.
- Handshake:
  - A beat transfers when in_valid && in_ready; the result transfers when out_valid && out_ready.
  - in_ready = !(s3_valid && !out_ready), i.e. the whole pipe advances or the whole pipe stalls.
  - Bubbles are not compressed during a stall.
  - Latency is exactly 3 cycles with no stall; throughput is 1 per cycle; results come out in order.
- Outputs are registered and held stable while out_valid && !out_ready.
- Stage 1, unpack/align:
  - Classify each operand: zero, subnormal, normal, inf, qNaN, sNaN.
  - Hidden bit = |exp. Subnormals use effective exponent 1.
  - Swap so that |A| >= |B| (compare {exp, frac}).
  - Right-shift the smaller significand by the exponent difference into MAN_W+4 bits (hidden, fraction, guard, round, sticky). Shift amounts >= MAN_W+3 collapse to sticky only.
- Stage 2, add/normalise:
  - Add or subtract significands per the effective sign.
  - Carry out → shift right by 1, exponent +1, sticky ORed.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not go below 1; if that limit applies, the result is subnormal and the stored exponent is 0.
  - Exact zero difference → sign = 0, except RDN gives sign = 1. Both zeros with equal signs keep that sign.
- Stage 3, round/pack:
  - Increment decision from {LSB, guard, round|sticky}, r_mode and sign:
    - RNE: ties to even.
    - RTZ: never increment.
    - RDN: increment iff negative and inexact.
    - RUP: increment iff positive and inexact.
    - RMM: increment iff guard = 1.
  - Rounding carry renormalises (exponent +1); a subnormal that rounds up to the hidden bit becomes the minimum normal.
- Overflow (exponent >= 2^EXP_W - 1 after rounding):
  - RNE / RMM → ±inf.
  - RTZ → ±max-finite.
  - RDN → +max-finite / -inf.
  - RUP → +inf / -max-finite.
  - flag_overflow = 1 and flag_inexact = 1.
- Specials (bypass the arithmetic, carried in a stage-1 tag):
  - Any NaN operand → canonical qNaN {0, all-ones exponent, 1, 0...}; flag_invalid = 1 only if an operand is an sNaN.
  - inf + (-inf) effective → canonical qNaN with flag_invalid = 1.
  - Single inf → that inf.
- flag_inexact = guard|round|sticky != 0 (or overflow).
- flag_underflow = result is tiny (exponent 0 before rounding) AND inexact.
- Flags are valid only with out_valid and are zero for special bypasses except NV.

Decomposition:
- Package fp_add_pkg:
  - rmode_e enum.
  - fp_class_e enum: ZERO, SUB, NORM, INF, QNAN, SNAN.
  - Stage struct typedefs parametrised via localparams of the package.
  - Function canonical_nan(EXP_W, MAN_W).
  - Function max_finite(EXP_W, MAN_W).
- Sub-module fp_lzc: parametrised leading-zero counter (WIDTH parameter, count output of $clog2(WIDTH)+1 bits, all-zero flag). It is instantiated in stage 2.

Test Plan:
1. 0x3F800000 + 0x40000000, RNE, out_ready = 1 → 0x40400000 appears exactly 3 cycles later, all flags 0.
2. 0x3F800000 + 0x33800000 (1.0 + 2^-24):
   - RNE → 0x3F800000 with NX = 1.
   - RUP → 0x3F800001 with NX = 1.
3. 0x7F7FFFFF + 0x7F7FFFFF:
   - RNE → 0x7F800000 with OF = 1 and NX = 1.
   - RTZ → 0x7F7FFFFF with OF = 1 and NX = 1.
4. 0x7F800000 + 0xFF800000 → 0x7FC00000 with NV = 1. Operand 0x7F800001 with any B → 0x7FC00000 with NV = 1.
5. 0x3F800000 with op_sub = 1, same operand:
   - RNE → 0x00000000.
   - RDN → 0x80000000.
   Subnormal case: 0x000A0000 + 0x000A0000 → 0x00140000, no flags.
6. Three back-to-back beats, out_ready held low for 4 cycles starting when the first result is valid → in_ready = 0 during the stall, the first result is held stable, and all three results are delivered in order with no loss or duplication. Asserting rst_n = 0 mid-stall clears out_valid immediately.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 adder/subtractor.
// Format-dependent stage structs live in the top, which owns EXP_W/MAN_W.
package fp_add_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int MAX_FP_W  = 64;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rmode_e;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

  // Tag for operands that bypass the arithmetic (NaN / infinity).
  typedef struct packed {
    logic active;
    logic is_nan;
    logic nv;
    logic sign;
  } special_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic rmode_e decode_rmode(input logic [2:0] raw);
    case (raw)
      3'b001:  return RTZ;
      3'b010:  return RDN;
      3'b011:  return RUP;
      3'b100:  return RMM;
      default: return RNE;
    endcase
  endfunction

  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic frac_zero, input logic quiet);
    if (exp_zero)       return frac_zero ? ZERO : SUB;
    else if (!exp_ones) return NORM;
    else if (frac_zero) return INF;
    else                return quiet ? QNAN : SNAN;
  endfunction

  function automatic logic [MAX_FP_W-1:0] canonical_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [MAX_FP_W-1:0] max_finite(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_add_if.sv
// Operand/result handshake bundle of the pipelined FP adder.
interface fp_add_if
  import fp_add_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
);
  localparam int FP_W = 1 + EXP_W + MAN_W;

  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] fp_a;
  logic [FP_W-1:0] fp_b;
  logic            op_sub;
  logic [2:0]      r_mode;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] fp_result;
  logic            flag_invalid;
  logic            flag_overflow;
  logic            flag_underflow;
  logic            flag_inexact;

  modport master (
    output in_valid, fp_a, fp_b, op_sub, r_mode, out_ready,
    input  in_ready, out_valid, fp_result,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  in_valid, fp_a, fp_b, op_sub, r_mode, out_ready,
    output in_ready, out_valid, fp_result,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; count = WIDTH when the input is all zero.
module fp_lzc #(
  parameter  int WIDTH = 27,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // NOTE: count gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage IEEE-754 adder/subtractor: unpack/align, add/normalise, round/pack.
// The whole pipe advances together; a stalled output freezes every stage.
module fp_add_pipe
  import fp_add_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input logic     clk,
  input logic     rst_n,
  fp_add_if.slave io
);

  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int E_W   = EXP_W + 2;
  localparam int LZ_W  = $clog2(SIG_W) + 1;
  localparam int RND_W = MAN_W + 2;

  localparam logic [E_W-1:0]      EXP_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic [MAX_FP_W-1:0] NAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [MAX_FP_W-1:0] MAX_FULL = max_finite(EXP_W, MAN_W);
  localparam logic [FP_W-1:0]     QNAN_VAL = NAN_FULL[FP_W-1:0];
  localparam logic [FP_W-2:0]     MAX_MAG  = MAX_FULL[FP_W-2:0];

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [E_W-1:0]   exp;
    logic [SIG_W-1:0] sig_big;
    logic [SIG_W-1:0] sig_small;
    rmode_e           rm;
    special_t         spc;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [E_W-1:0]   exp;
    logic [SIG_W-1:0] mant;
    rmode_e           rm;
    special_t         spc;
  } s2_t;

  logic      s1_valid, s2_valid, out_valid_q;
  s1_t       s1_d, s1_q;
  s2_t       s2_d, s2_q;
  logic [FP_W-1:0] res_d, res_q;
  fflags_t   flags_d, flags_q;
  logic      advance;

  assign advance     = !(out_valid_q && !io.out_ready);
  assign io.in_ready = advance;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic             sa, sb_raw, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb;
  logic             a_ge_b, a_nan, b_nan, any_snan, a_inf, b_inf, inf_clash;
  logic [E_W-1:0]   ea_eff, eb_eff, diff;
  logic [SIG_W-1:0] siga, sigb, sig_small, shifted, lost_mask;

  assign {sa, ea, fa}     = io.fp_a;
  assign {sb_raw, eb, fb} = io.fp_b;
  assign sb     = sb_raw ^ io.op_sub;
  assign ca     = classify(&ea, ~|ea, ~|fa, fa[MAN_W-1]);
  assign cb     = classify(&eb, ~|eb, ~|fb, fb[MAN_W-1]);
  assign a_ge_b = {ea, fa} >= {eb, fb};
  assign ea_eff = (ea == '0) ? E_W'(1) : E_W'(ea);
  assign eb_eff = (eb == '0) ? E_W'(1) : E_W'(eb);
  assign siga   = {|ea, fa, 3'b000};
  assign sigb   = {|eb, fb, 3'b000};

  assign a_nan     = (ca == QNAN) || (ca == SNAN);
  assign b_nan     = (cb == QNAN) || (cb == SNAN);
  assign any_snan  = (ca == SNAN) || (cb == SNAN);
  assign a_inf     = (ca == INF);
  assign b_inf     = (cb == INF);
  assign inf_clash = a_inf && b_inf && (sa != sb);

  always_comb begin
    s1_d      = '0;
    sig_small = a_ge_b ? sigb : siga;
    diff      = a_ge_b ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
    shifted   = sig_small >> diff;
    lost_mask = ~({SIG_W{1'b1}} << diff);

    s1_d.sign    = a_ge_b ? sa : sb;
    s1_d.eff_sub = sa ^ sb;
    s1_d.exp     = a_ge_b ? ea_eff : eb_eff;
    s1_d.sig_big = a_ge_b ? siga : sigb;
    s1_d.rm      = decode_rmode(io.r_mode);

    // Far-away operands only contribute to sticky.
    if (diff >= E_W'(MAN_W + 3))
      s1_d.sig_small = {{(SIG_W-1){1'b0}}, |sig_small};
    else
      s1_d.sig_small = {shifted[SIG_W-1:1], shifted[0] | (|(sig_small & lost_mask))};

    s1_d.spc.active = a_nan || b_nan || a_inf || b_inf;
    s1_d.spc.is_nan = a_nan || b_nan || inf_clash;
    s1_d.spc.nv     = any_snan || inf_clash;
    s1_d.spc.sign   = a_inf ? sa : sb;
  end

  // ---------------- Stage 2: add/subtract, normalise ----------------
  logic [SIG_W:0]   sum;
  logic [LZ_W-1:0]  lz_cnt;
  logic             lz_zero;
  logic [E_W-1:0]   lz_ext, shift_lim, shift_amt;

  assign sum = s1_q.eff_sub ? ({1'b0, s1_q.sig_big} - {1'b0, s1_q.sig_small})
                            : ({1'b0, s1_q.sig_big} + {1'b0, s1_q.sig_small});

  fp_lzc #(.WIDTH(SIG_W)) u_lzc (
    .value    (sum[SIG_W-1:0]),
    .count    (lz_cnt),
    .all_zero (lz_zero)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.rm   = s1_q.rm;
    s2_d.spc  = s1_q.spc;
    s2_d.sign = s1_q.sign;
    lz_ext    = E_W'(lz_cnt);
    shift_lim = s1_q.exp - E_W'(1);
    shift_amt = (lz_ext > shift_lim) ? shift_lim : lz_ext;

    if (sum[SIG_W]) begin
      s2_d.mant = {sum[SIG_W:2], sum[1] | sum[0]};
      s2_d.exp  = s1_q.exp + E_W'(1);
    end else begin
      s2_d.mant = sum[SIG_W-1:0] << shift_amt;
      s2_d.exp  = s1_q.exp - shift_amt;
    end

    // No hidden bit after the limited shift: the value is subnormal (or zero).
    if (!s2_d.mant[SIG_W-1]) s2_d.exp = '0;

    if (lz_zero && !sum[SIG_W])
      s2_d.sign = s1_q.eff_sub ? (s1_q.rm == RDN) : s1_q.sign;
  end

  // ---------------- Stage 3: round, overflow, pack ----------------
  logic             lsb, grd, rs, inexact, inc, tiny, ovf, to_inf;
  logic [RND_W-1:0] rounded;
  logic [E_W-1:0]   exp_r;
  logic [MAN_W-1:0] frac_r;

  always_comb begin
    lsb     = s2_q.mant[3];
    grd     = s2_q.mant[2];
    rs      = |s2_q.mant[1:0];
    inexact = grd | rs;
    tiny    = (s2_q.exp == '0);

    case (s2_q.rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = s2_q.sign & inexact;
      RUP:     inc = ~s2_q.sign & inexact;
      RMM:     inc = grd;
      default: inc = grd & (rs | lsb);
    endcase

    rounded = {1'b0, s2_q.mant[SIG_W-1:3]} + RND_W'(inc);
    exp_r   = tiny ? E_W'(rounded[MAN_W]) : (s2_q.exp + E_W'(rounded[MAN_W+1]));
    frac_r  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    ovf     = (exp_r >= EXP_MAX);
    to_inf  = (s2_q.rm == RNE) || (s2_q.rm == RMM) ||
              ((s2_q.rm == RDN) && s2_q.sign) || ((s2_q.rm == RUP) && !s2_q.sign);

    flags_d = '0;
    if (s2_q.spc.active) begin
      res_d      = s2_q.spc.is_nan ? QNAN_VAL
                                   : {s2_q.spc.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d.nv = s2_q.spc.nv;
    end else if (ovf) begin
      res_d      = to_inf ? {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {s2_q.sign, MAX_MAG};
      flags_d.of = 1'b1;
      flags_d.nx = 1'b1;
    end else begin
      res_d      = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};
      flags_d.nx = inexact;
      flags_d.uf = tiny & inexact;
    end
  end

  // ---------------- Registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      s1_valid    <= io.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  // NOTE: stage payloads carry no reset; they are qualified by the reset valid bits.
  always_ff @(posedge clk) begin
    if (advance && io.in_valid) s1_q <= s1_d;
    if (advance && s1_valid)    s2_q <= s2_d;
  end

  assign io.out_valid      = out_valid_q;
  assign io.fp_result      = res_q;
  assign io.flag_invalid   = flags_q.nv;
  assign io.flag_overflow  = flags_q.of;
  assign io.flag_underflow = flags_q.uf;
  assign io.flag_inexact   = flags_q.nx;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe (binary32): directed vectors, stall and reset.
module tb_fp_add_pipe;

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_NV   = 4'b1000;
  localparam logic [3:0] F_OF   = 4'b0100;
  localparam logic [3:0] F_NX   = 4'b0001;

  localparam logic [2:0] M_RNE = 3'b000, M_RTZ = 3'b001, M_RDN = 3'b010,
                         M_RUP = 3'b011, M_RMM = 3'b100;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  flg;
    int          issue;
    bit          chk_lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   next_id = 0;
  exp_t sb[$];

  fp_add_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [2:0] rm, input logic [31:0] res, input logic [3:0] flg,
                      input bit lat = 1'b0);
    bit   rdy;
    int   tries;
    int   issue;
    exp_t e;
    rdy = 1'b0;
    tries = 0;
    issue = 0;
    while (!rdy && tries < 50) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.fp_a     = a;
      bus.fp_b     = b;
      bus.op_sub   = sub;
      bus.r_mode   = rm;
      #1;
      rdy   = bus.in_ready;
      issue = cyc;
      @(posedge clk);
      tries++;
    end
    check("accept", {31'b0, rdy}, 32'd1);
    if (rdy) begin
      e.id = next_id; e.res = res; e.flg = flg; e.issue = issue; e.chk_lat = lat;
      sb.push_back(e);
      next_id++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", bus.fp_result, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          check($sformatf("res#%0d", e.id), bus.fp_result, e.res);
          check($sformatf("flags#%0d", e.id),
                {28'b0, bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact},
                {28'b0, e.flg});
          if (e.chk_lat) check($sformatf("latency#%0d", e.id), cyc - e.issue, 32'd3);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fp_a      = '0;
    bus.fp_b      = '0;
    bus.op_sub    = 1'b0;
    bus.r_mode    = M_RNE;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.fp_result, 32'h0);
    check("rst_flags", {28'b0, bus.flag_invalid, bus.flag_overflow,
                        bus.flag_underflow, bus.flag_inexact}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Basic add with latency check, then rounding around 1.0 + 2^-24.
    send(32'h3F800000, 32'h40000000, 1'b0, M_RNE, 32'h40400000, F_NONE, 1'b1);
    idle();
    drain();
    send(32'h3F800000, 32'h33800000, 1'b0, M_RNE, 32'h3F800000, F_NX);
    send(32'h3F800000, 32'h33800000, 1'b0, M_RUP, 32'h3F800001, F_NX);
    send(32'h3F800000, 32'h33800000, 1'b0, M_RMM, 32'h3F800001, F_NX);
    send(32'h3F800000, 32'h33800000, 1'b0, M_RDN, 32'h3F800000, F_NX);
    send(32'h3F800000, 32'h33C00000, 1'b0, M_RNE, 32'h3F800001, F_NX);
    // Overflow in each direction.
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, M_RNE, 32'h7F800000, F_OF | F_NX);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, M_RTZ, 32'h7F7FFFFF, F_OF | F_NX);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, M_RDN, 32'hFF800000, F_OF | F_NX);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, M_RUP, 32'hFF7FFFFF, F_OF | F_NX);
    // Specials.
    send(32'h7F800000, 32'hFF800000, 1'b0, M_RNE, 32'h7FC00000, F_NV);
    send(32'h7F800001, 32'h3F800000, 1'b0, M_RNE, 32'h7FC00000, F_NV);
    send(32'h7FC00000, 32'h3F800000, 1'b0, M_RNE, 32'h7FC00000, F_NONE);
    send(32'h7F800000, 32'h7F800000, 1'b1, M_RNE, 32'h7FC00000, F_NV);
    send(32'h3F800000, 32'h7F800000, 1'b1, M_RNE, 32'hFF800000, F_NONE);
    // Cancellation, zeros, subnormals.
    send(32'h3F800000, 32'h3F800000, 1'b1, M_RNE, 32'h00000000, F_NONE);
    send(32'h3F800000, 32'h3F800000, 1'b1, M_RDN, 32'h80000000, F_NONE);
    send(32'h80000000, 32'h80000000, 1'b0, M_RNE, 32'h80000000, F_NONE);
    send(32'h3F800001, 32'h3F800000, 1'b1, M_RNE, 32'h34000000, F_NONE);
    send(32'h40000000, 32'hBF800000, 1'b0, M_RNE, 32'h3F800000, F_NONE);
    send(32'h3F800000, 32'hBF800000, 1'b1, M_RNE, 32'h40000000, F_NONE);
    send(32'h000A0000, 32'h000A0000, 1'b0, M_RNE, 32'h00140000, F_NONE);
    send(32'h00400000, 32'h00400000, 1'b0, M_RNE, 32'h00800000, F_NONE);
    idle();
    drain();

    // Three back-to-back beats, output stalled for 4 cycles.
    send(32'h3F800000, 32'h40000000, 1'b0, M_RNE, 32'h40400000, F_NONE);
    send(32'h40000000, 32'h40000000, 1'b0, M_RNE, 32'h40800000, F_NONE);
    send(32'h3F800000, 32'h3F800000, 1'b1, M_RDN, 32'h80000000, F_NONE);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out_valid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stall_hold", bus.fp_result, 32'h40400000);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    drain();
    repeat (4) @(negedge clk);

    // Asynchronous reset while a result is stalled at the output.
    send(32'h3F800000, 32'h40000000, 1'b0, M_RNE, 32'h40400000, F_NONE);
    idle();
    wait_out_valid();
    bus.out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_result", bus.fp_result, 32'h0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    send(32'h40000000, 32'h3F800000, 1'b1, M_RNE, 32'h3F800000, F_NONE);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
